// File: rtl/st2_ctrl_pkg.sv
// st2_ctrl_pkg: opcode/funct constants, control encodings and the ID/EX control bundle
package st2_ctrl_pkg;
   localparam logic [3:0] OP_HALT  = 4'b0000;
   localparam logic [3:0] OP_JMP   = 4'b0001;
   localparam logic [3:0] OP_BGT   = 4'b0100;
   localparam logic [3:0] OP_BLT   = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_ANDI  = 4'b1000;
   localparam logic [3:0] OP_ORI   = 4'b1001;
   localparam logic [3:0] OP_LBU   = 4'b1010;
   localparam logic [3:0] OP_SB    = 4'b1011;
   localparam logic [3:0] OP_LW    = 4'b1100;
   localparam logic [3:0] OP_SW    = 4'b1101;
   localparam logic [3:0] OP_RTYPE = 4'b1111;
   localparam logic [3:0] FN_ADD   = 4'b0000;
   localparam logic [3:0] FN_SUB   = 4'b0001;
   localparam logic [3:0] FN_MUL   = 4'b0100;
   localparam logic [3:0] FN_DIV   = 4'b0101;
   localparam logic [3:0] FN_MOVE  = 4'b0111;
   localparam logic [3:0] FN_SWAP  = 4'b1000;
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] CTRL_NONE = 4'b0000;
   localparam logic [1:0] SE_ZERO  = 2'b00;
   localparam logic [1:0] SE_4     = 2'b01;
   localparam logic [1:0] SE_8     = 2'b10;
   localparam logic [1:0] SE_12    = 2'b11;
   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_BYTE = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;
   localparam logic [1:0] RW_NONE  = 2'b00;
   localparam logic [1:0] RW_ONE   = 2'b01;
   localparam logic [1:0] RW_BOTH  = 2'b11;
   typedef struct packed {
      logic [1:0] se_sel;
      logic [1:0] reg_write;
      logic [1:0] mem_read;
      logic [1:0] mem_write;
      logic [3:0] alu_op;
      logic [3:0] ctrl_op;
      logic       r15_write;
      logic       alu_src1;
      logic       alu_src2;
      logic       mem_to_reg;
   } ctrl_bundle_t;
   localparam ctrl_bundle_t BUBBLE = '0;
endpackage

// File: rtl/st2_decode_comb.sv
// st2_decode_comb: pure combinational OpCode/Funct to control bundle decode
module st2_decode_comb
   import st2_ctrl_pkg::*;
(
   input  logic [3:0]   OpCode,
   input  logic [3:0]   Funct,
   output ctrl_bundle_t ctrl,
   output logic         is_muldiv,
   output logic         is_halt,
   output logic         is_illegal
);
   assign is_muldiv = (OpCode == OP_RTYPE) && (Funct == FN_MUL || Funct == FN_DIV);
   assign is_halt   = (OpCode == OP_HALT);
   // decode one instruction; unknown codes flag illegal and leave the bundle empty
   always_comb begin
      ctrl = BUBBLE;
      is_illegal = 1'b0;
      case (OpCode)
         OP_RTYPE: begin
            case (Funct)
               FN_ADD, FN_SUB, FN_MUL, FN_DIV, FN_MOVE, FN_SWAP: begin
                  ctrl.alu_op    = Funct;
                  ctrl.reg_write = (Funct == FN_SWAP) ? RW_BOTH : RW_ONE;
                  ctrl.r15_write = (Funct == FN_MUL || Funct == FN_DIV || Funct == FN_SWAP);
                  ctrl.alu_src1  = (Funct == FN_MOVE || Funct == FN_SWAP);
               end
               default: is_illegal = 1'b1;
            endcase
         end
         OP_ANDI, OP_ORI: begin
            ctrl.alu_op    = (OpCode == OP_ANDI) ? ALU_AND : ALU_OR;
            ctrl.reg_write = RW_ONE;
            ctrl.se_sel    = SE_ZERO;
            ctrl.alu_src2  = 1'b1;
         end
         OP_LBU, OP_LW: begin
            ctrl.alu_op     = ALU_ADD;
            ctrl.reg_write  = RW_ONE;
            ctrl.mem_read   = (OpCode == OP_LBU) ? MEM_BYTE : MEM_WORD;
            ctrl.mem_to_reg = 1'b1;
            ctrl.se_sel     = SE_4;
            ctrl.alu_src2   = 1'b1;
         end
         OP_SB, OP_SW: begin
            ctrl.alu_op    = ALU_ADD;
            ctrl.mem_write = (OpCode == OP_SB) ? MEM_BYTE : MEM_WORD;
            ctrl.se_sel    = SE_4;
            ctrl.alu_src2  = 1'b1;
         end
         OP_BGT, OP_BLT, OP_BEQ: begin
            ctrl.alu_op  = ALU_SUB;
            ctrl.ctrl_op = OpCode;
            ctrl.se_sel  = SE_8;
         end
         OP_JMP: begin
            ctrl.ctrl_op = OpCode;
            ctrl.se_sel  = SE_12;
         end
         OP_HALT: ctrl.ctrl_op = CTRL_NONE;
         default: is_illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/st2_decode_ctrl_pipe.sv
// st2_decode_ctrl_pipe: registered stage-2 control decode with handshake, stall, flush, MUL/DIV blocking and HALT
module st2_decode_ctrl_pipe
   import st2_ctrl_pkg::*;
#(
   parameter int MUL_CYC = 3,
   parameter int DIV_CYC = 8,
   parameter int CNT_W   = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] OpCode,
   input  logic [3:0] Funct,
   input  logic       stall_in,
   input  logic       flush,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] SE_Sel,
   output logic [1:0] regWrite,
   output logic [1:0] memRead,
   output logic [1:0] memWrite,
   output logic [3:0] ALUop,
   output logic [3:0] ctrlOp,
   output logic       R15Write,
   output logic       ALUsrc1,
   output logic       ALUsrc2,
   output logic       memToReg,
   output logic       illegal,
   output logic       halted
);
   typedef enum logic [1:0] {RUN, BUSY, HALT} state_t;
   localparam logic [CNT_W-1:0] MUL_LEN = CNT_W'(MUL_CYC - 1);
   localparam logic [CNT_W-1:0] DIV_LEN = CNT_W'(DIV_CYC - 1);
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] busy_len;
   ctrl_bundle_t     dec;
   ctrl_bundle_t     ctrl_q;
   logic             dec_muldiv;
   logic             dec_halt;
   logic             dec_illegal;
   logic             accept;
   st2_decode_comb u_dec (
      .OpCode     (OpCode),
      .Funct      (Funct),
      .ctrl       (dec),
      .is_muldiv  (dec_muldiv),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal)
   );
   assign busy_len = Funct[0] ? DIV_LEN : MUL_LEN;
   assign in_ready = (state == RUN) && !stall_in;
   assign accept   = in_valid && in_ready && !flush;
   assign halted   = (state == HALT);
   assign SE_Sel   = ctrl_q.se_sel;
   assign regWrite = ctrl_q.reg_write;
   assign memRead  = ctrl_q.mem_read;
   assign memWrite = ctrl_q.mem_write;
   assign ALUop    = ctrl_q.alu_op;
   assign ctrlOp   = ctrl_q.ctrl_op;
   assign R15Write = ctrl_q.r15_write;
   assign ALUsrc1  = ctrl_q.alu_src1;
   assign ALUsrc2  = ctrl_q.alu_src2;
   assign memToReg = ctrl_q.mem_to_reg;
   // ID/EX register, illegal pulse and RUN/BUSY/HALT sequencing; the busy count runs even while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         cnt       <= '0;
         ctrl_q    <= BUBBLE;
         out_valid <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         illegal <= accept && dec_illegal;
         if (!stall_in) begin
            ctrl_q    <= (accept && !dec_illegal) ? dec : BUBBLE;
            out_valid <= accept && !dec_illegal;
         end
         case (state)
            RUN: begin
               if (accept && dec_halt) state <= HALT;
               else if (accept && dec_muldiv && busy_len != '0) begin
                  cnt   <= busy_len;
                  state <= BUSY;
               end
            end
            BUSY: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= RUN;
            end
            default: state <= HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_st2_decode_ctrl_pipe.sv
// tb_st2_decode_ctrl_pipe: directed and random checks against a cycle-level behavioural model
module tb_st2_decode_ctrl_pipe;
   localparam int MUL_CYC = 3;
   localparam int DIV_CYC = 8;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [3:0] OpCode = '0;
   logic [3:0] Funct = '0;
   logic stall_in = 1'b0;
   logic flush = 1'b0;
   logic in_ready, out_valid, R15Write, ALUsrc1, ALUsrc2, memToReg, illegal, halted;
   logic [1:0] SE_Sel, regWrite, memRead, memWrite;
   logic [3:0] ALUop, ctrlOp;
   logic [20:0] dut_vec;
   int n_tests = 0;
   int n_fail = 0;
   int m_busy = 0;
   bit m_halt = 0;
   bit m_ill = 0;
   logic [20:0] m_out = '0;
   bit last_acc = 0;
   int tries = 0;
   int halt_age = 0;

   st2_decode_ctrl_pipe #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .OpCode(OpCode), .Funct(Funct),
      .stall_in(stall_in), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
      .SE_Sel(SE_Sel), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
      .ALUop(ALUop), .ctrlOp(ctrlOp), .R15Write(R15Write), .ALUsrc1(ALUsrc1),
      .ALUsrc2(ALUsrc2), .memToReg(memToReg), .illegal(illegal), .halted(halted)
   );

   always #5 clk = ~clk;
   assign dut_vec = {out_valid, SE_Sel, regWrite, memRead, memWrite, ALUop, ctrlOp,
                     R15Write, ALUsrc1, ALUsrc2, memToReg};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // expected control fields straight from the instruction-class rules
   function automatic logic [19:0] ref_dec(input logic [3:0] op, input logic [3:0] fn,
                                           output bit ill, output bit md, output bit hlt);
      bit r, imm, ld, st, br, jmp;
      logic [1:0] se, rw, mr, mw, sz;
      logic [3:0] alu, ctl;
      r   = (op == 15) && (fn inside {0, 1, 4, 5, 7, 8});
      imm = op inside {8, 9};
      ld  = op inside {10, 12};
      st  = op inside {11, 13};
      br  = op inside {4, 5, 6};
      jmp = (op == 1);
      hlt = (op == 0);
      ill = !(r || imm || ld || st || br || jmp || hlt);
      md  = r && (fn == 4 || fn == 5);
      sz  = (op == 10 || op == 11) ? 2'd1 : 2'd2;
      se  = imm ? 2'd0 : (ld || st) ? 2'd1 : br ? 2'd2 : jmp ? 2'd3 : 2'd0;
      rw  = r ? ((fn == 8) ? 2'd3 : 2'd1) : (imm || ld) ? 2'd1 : 2'd0;
      mr  = ld ? sz : 2'd0;
      mw  = st ? sz : 2'd0;
      alu = r ? fn : (op == 8) ? 4'd2 : (op == 9) ? 4'd3 : br ? 4'd1 : 4'd0;
      ctl = (br || jmp || hlt) ? op : 4'd0;
      return {se, rw, mr, mw, alu, ctl, r && (fn inside {4, 5, 8}), r && (fn inside {7, 8}),
              imm || ld || st, ld};
   endfunction

   // one clock: drive, check ready, advance the model, check registered outputs
   task automatic step(input bit r, input bit v, input logic [3:0] op, input logic [3:0] fn,
                       input bit st, input bit fl);
      bit ready, acc, ill, md, hlt;
      logic [19:0] d;
      rst = r; in_valid = v; OpCode = op; Funct = fn; stall_in = st; flush = fl;
      #1;
      ready = !m_halt && m_busy == 0 && !st;
      if (!r) check("in_ready", in_ready, ready);
      d = ref_dec(op, fn, ill, md, hlt);
      acc = !r && v && ready && !fl;
      last_acc = acc;
      if (r) begin
         m_busy = 0; m_halt = 0; m_ill = 0; m_out = '0;
      end else begin
         m_ill = acc && ill;
         if (m_busy > 0) m_busy--;
         if (!st) m_out = (acc && !ill) ? {1'b1, d} : '0;
         if (acc && md) m_busy = ((fn == 5) ? DIV_CYC : MUL_CYC) - 1;
         if (acc && hlt) m_halt = 1;
      end
      @(posedge clk);
      #1;
      check("ctrl", dut_vec, m_out);
      check("illegal", illegal, m_ill);
      check("halted", halted, m_halt);
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] fn);
      tries = 0;
      for (int k = 0; k < 20; k++) begin
         tries++;
         step(0, 1, op, fn, 0, 0);
         if (last_acc) break;
      end
   endtask

   logic [7:0] walk [17] = '{8'hF0, 8'hF1, 8'hF4, 8'hF5, 8'hF7, 8'hF8, 8'h80, 8'h90, 8'hA0,
                             8'hB0, 8'hC0, 8'hD0, 8'h40, 8'h50, 8'h60, 8'h10, 8'h00};

   initial begin
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("rst_vec", dut_vec, 21'd0);
      for (int i = 0; i < 17; i++) begin
         issue(walk[i][7:4], walk[i][3:0]);
         if (walk[i] == 8'hF0) begin
            check("add_aluop", ALUop, 4'b0000);
            check("add_regwrite", regWrite, 2'b01);
         end
         if (walk[i] == 8'hC0) begin
            check("lw_memread", memRead, 2'b10);
            check("lw_memtoreg", memToReg, 1'b1);
            check("lw_sesel", SE_Sel, 2'b01);
            check("lw_alusrc2", ALUsrc2, 1'b1);
         end
      end
      check("walk_halted", halted, 1'b1);
      step(1, 0, 0, 0, 0, 0);
      issue(4'hF, 4'h4);
      issue(4'hF, 4'h0);
      check("mul_gap", tries, 3);
      issue(4'hF, 4'h5);
      issue(4'hF, 4'h0);
      check("div_gap", tries, 8);
      issue(4'hF, 4'h0);
      for (int k = 0; k < 3; k++) step(0, 1, 4'hC, 4'h0, 1, 0);
      check("stall_hold_add", ALUop, 4'b0000);
      issue(4'hC, 4'h0);
      check("lw_after_stall", tries, 1);
      issue(4'hF, 4'h4);
      step(0, 1, 4'hF, 4'h0, 1, 0);
      step(0, 1, 4'hF, 4'h0, 1, 0);
      issue(4'hF, 4'h0);
      check("busy_under_stall", tries, 1);
      issue(4'h6, 4'h0);
      step(0, 1, 4'hD, 4'h0, 0, 1);
      check("flush_sw", memWrite, 2'b00);
      step(0, 1, 4'h0, 4'h0, 0, 1);
      check("flush_halt", halted, 1'b0);
      step(0, 1, 4'h7, 4'h0, 0, 0);
      check("ill_op", illegal, 1'b1);
      step(0, 1, 4'hF, 4'hF, 0, 0);
      check("ill_fn", illegal, 1'b1);
      step(0, 0, 4'h0, 4'h0, 0, 0);
      check("ill_drop", illegal, 1'b0);
      issue(4'h0, 4'h0);
      for (int k = 0; k < 10; k++) step(0, 1, 4'hF, 4'h0, 0, 0);
      step(0, 1, 4'h5, 4'h4, 0, 0);
      step(1, 1, 4'hF, 4'h0, 0, 0);
      issue(4'hF, 4'h5);
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("rst_mid_busy", dut_vec, 21'd0);
      for (int i = 0; i < 800; i++) begin
         logic [3:0] op, fn;
         bit r;
         op = 4'($urandom_range(0, 15));
         fn = ($urandom_range(0, 9) < 7) ? walk[$urandom_range(0, 5)][3:0] : 4'($urandom_range(0, 15));
         halt_age = m_halt ? halt_age + 1 : 0;
         r = (halt_age > 3) || ($urandom_range(0, 99) == 0);
         step(r, $urandom_range(0, 9) < 8, op, fn, $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/st2_decode_ctrl_pipe.md
# st2_decode_ctrl_pipe

Parametrised, registered successor to the stage-2 control decoder of the 16-bit pipelined datapath. Decodes OpCode/Funct into the full control bundle and holds it in the ID/EX control register. Adds a valid/ready handshake, downstream stall, branch flush, multi-cycle MUL/DIV issue blocking, sticky HALT and an illegal-instruction flag. Sits between the IF/ID register and the EX stage; `in_ready` drives the IF/ID hold.

## Interface
Parameters:
- MUL_CYC, 3, EX occupancy of MUL in cycles (>=1)
- DIV_CYC, 8, EX occupancy of DIV in cycles (>=1)
- CNT_W, 4, busy counter width; must satisfy 2^CNT_W > max(MUL_CYC, DIV_CYC)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IF/ID holds an instruction
- OpCode  in  4  instruction [15:12]
- Funct  in  4  instruction [3:0]; used only when OpCode=1111
- stall_in  in  1  downstream hold; ID/EX register must not change
- flush  in  1  taken branch/jump; kill the instruction currently in ID
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready
- out_valid  out  1  ID/EX control register holds a real instruction
- SE_Sel, regWrite, memRead, memWrite  out  2 each  registered control
- ALUop, ctrlOp  out  4 each  registered control
- R15Write, ALUsrc1, ALUsrc2, memToReg  out  1 each  registered control
- illegal  out  1  one-cycle pulse: undefined opcode/funct accepted
- halted  out  1  sticky; set after HALT is accepted

## Operation
- Decode (fixed): R-type 1111 with Funct 0000 ADD, 0001 SUB, 0100 MUL, 0101 DIV, 0111 MOVE, 1000 SWAP; 1000 ANDI, 1001 ORI, 1010 LBU, 1011 SB, 1100 LW, 1101 SW, 0100 BGT, 0101 BLT, 0110 BEQ, 0001 JMP, 0000 HALT. Any other code is illegal.
- ALUop equals Funct for R-type; ANDI 0010, ORI 0011; loads and stores 0000 (add); branches 0001 (sub).
- ctrlOp equals OpCode for branch/JMP/HALT; otherwise 0000.
- regWrite: 01 for ALU/immediate/load; 11 for SWAP (both registers); 00 otherwise.
- R15Write=1 for MUL, DIV and SWAP only.
- memRead/memWrite: 01 byte (LBU/SB), 10 word (LW/SW), 00 otherwise. memToReg=1 for loads.
- SE_Sel: 00 zero-extend (ANDI/ORI), 01 sign-extend 4-bit (memory), 10 sign-extend 8-bit (branch), 11 sign-extend 12-bit (JMP).
- ALUsrc2=1 for immediate and memory ops. ALUsrc1=1 for MOVE and SWAP.
- Bubble: all control outputs 0 and out_valid=0.
- FSM has three states: RUN, BUSY, HALT.
  - RUN: in_ready = !stall_in. On accept, the register loads the decode and out_valid=1.
  - Accepting MUL or DIV with CYC>1 loads cnt=CYC-1 and moves to BUSY.
  - Accepting HALT moves to HALT.
  - Accepting an illegal instruction loads a bubble and pulses illegal.
- BUSY: in_ready=0. cnt decrements every cycle, including under stall_in. Move to RUN when cnt=1. If !stall_in, the register loads a bubble.
- HALT: in_ready=0, halted=1, bubble loaded when !stall_in. Only rst exits.
- Priority, highest first: rst, stall_in (register holds), flush, accept.
- flush in RUN with !stall_in: input discarded, register loads a bubble, no state change, no illegal pulse. A HALT or MUL flushed in the same cycle has no effect.
- flush in BUSY or HALT does not alter cnt or state.
- No accept with !stall_in in RUN: register loads a bubble.

## Timing
- Latency: accepted at edge N, controls and out_valid valid after edge N.
- MUL/DIV: in_ready low for exactly CYC-1 cycles after the accept edge; CYC=1 gives no stall.
- illegal is high for the one cycle after the accepting edge.
- Reset values: all control outputs 0, out_valid 0, illegal 0, halted 0, cnt 0, state RUN. in_ready = !stall_in during the cycle following reset.
- Reset mid-BUSY or mid-HALT returns to RUN on the next edge.

## Structure
- Package st2_ctrl_pkg contains:
  - opcode/funct constants
  - ALUop, ctrlOp, SE_Sel and mem-size encodings
  - packed struct ctrl_bundle_t
  - localparam BUBBLE
- Sub-module st2_decode_comb: pure combinational OpCode/Funct to {ctrl_bundle_t, is_muldiv, is_halt, is_illegal}.
- Top-level block: FSM, counter, ID/EX register.

## Test plan
- Walk all 17 legal instructions back-to-back, stall_in=0 → one output per cycle. Check ADD gives ALUop=0000, regWrite=01, and LW gives memRead=10, memToReg=1, SE_Sel=01, ALUsrc2=1.
- MUL then ADD, MUL_CYC=3 → in_ready low for 2 cycles, 2 bubbles, ADD out 3 cycles after MUL. DIV with DIV_CYC=8 → 7 bubbles.
- stall_in held 3 cycles during LW → outputs frozen, in_ready=0, no instruction lost. stall_in during BUSY → counter still expires on time.
- BEQ followed by flush with SW in ID → SW replaced by bubble, memWrite never asserted. flush and HALT in the same cycle → halted stays 0.
- OpCode 0111 and R-type Funct 1111 → illegal pulses 1 cycle each, bubble output, in_ready stays 1.
- HALT, then in_valid held high 10 cycles → halted=1, in_ready=0 throughout. rst → all outputs 0, halted=0, RUN.
